// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: per-channel divided clock, end-of-period tick,
// and divisor updates that take effect only at period boundaries.
module clk_divider_multi #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 8,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    output logic [N_CH-1:0]  out_clk,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  upd_pending
);

    localparam int               RST_DIV_I = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(RST_DIV_I);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

    function automatic logic [DIV_W-1:0] f_deff(input logic [DIV_W-1:0] d);
        return (d < TWO) ? TWO : d;
    endfunction

    // High phase is ceil(D/2) so odd divisors put the extra cycle in the high half.
    function automatic logic [DIV_W-1:0] f_high(input logic [DIV_W-1:0] d);
        return d - (d >> 1);
    endfunction

    logic [DIV_W-1:0] w_wr_div;
    assign w_wr_div = f_deff(wr_div);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] r_act_div;
        logic [DIV_W-1:0] r_pend_div;
        logic [DIV_W-1:0] r_cnt;
        logic             r_pend;
        logic             r_out;
        logic             r_tick;

        logic             w_wr;
        logic             w_bnd;
        logic [DIV_W-1:0] w_nxt;
        logic [DIV_W-1:0] w_new_div;
        logic [DIV_W-1:0] w_dis_div;

        assign w_wr  = wr_en && (wr_ch == CH_W'(i));
        assign w_bnd = (r_cnt == r_act_div - ONE) || sync;
        assign w_nxt = w_bnd ? '0 : r_cnt + ONE;

        // At a boundary a same-edge write beats an older pending divisor.
        assign w_new_div = !w_bnd ? r_act_div :
                           w_wr   ? w_wr_div  :
                           r_pend ? r_pend_div : r_act_div;

        assign w_dis_div = w_wr   ? w_wr_div  :
                           r_pend ? r_pend_div : r_act_div;

        always_ff @(posedge in_clk) begin
            if (reset) begin
                r_act_div  <= RST_DIV;
                r_pend_div <= RST_DIV;
                r_cnt      <= RST_DIV - ONE;
                r_pend     <= 1'b0;
                r_out      <= 1'b0;
                r_tick     <= 1'b0;
            end else if (!ch_en[i]) begin
                // Parking at D-1 makes the first enabled edge wrap to phase 0, high.
                r_act_div <= w_dis_div;
                r_cnt     <= w_dis_div - ONE;
                r_pend    <= 1'b0;
                r_out     <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_cnt     <= w_nxt;
                r_act_div <= w_new_div;
                if (w_bnd) begin
                    r_pend <= 1'b0;
                end else if (w_wr) begin
                    r_pend     <= 1'b1;
                    r_pend_div <= w_wr_div;
                end
                r_out  <= (w_nxt < f_high(w_new_div));
                r_tick <= (w_nxt == w_new_div - ONE);
            end
        end

        assign out_clk[i]     = r_out;
        assign tick[i]        = r_tick;
        assign upd_pending[i] = r_pend;
    end

endmodule
